// File: rtl/ro_puf_sel_counter.sv
// RO PUF channel selector and windowed rising-edge counter.
// Optional build macro ROSEL_SATURATE_EN: running counter saturates instead of wrapping.
//
// state  | meaning
// IDLE   | waiting for start; sel/window latched on accept
// SETTLE | 3 cycles flushing sync1/sync2/sync3 from the new channel; counter cleared
// COUNT  | window cycles counting sync2 & ~sync3
// DONE   | single cycle; result moved to the output registers
module ro_puf_sel_counter #(
    parameter int N_IN  = 16,
    parameter int SEL_W = $clog2(N_IN),
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IN-1:0]  ro_in,
    input  logic             start,
    input  logic [SEL_W-1:0] sel,
    input  logic [WIN_W-1:0] window,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             sel_err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] COUNT  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]       state;
    logic [SEL_W-1:0] sel_q;
    logic [WIN_W-1:0] win_q;
    logic [WIN_W-1:0] timer;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             err_q;
    logic             sync1, sync2, sync3;
    logic             ro_sel;
    logic             edge_det;
    logic             sel_bad;
    logic             done_r, sel_err_r;
    logic [CNT_W-1:0] count_r;

    // Mux driven only from the latched select so port changes cannot disturb a run
    always_comb begin
        ro_sel = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (sel_q == SEL_W'(i)) ro_sel = ro_in[i];
        end
    end

    assign sel_bad  = ({1'b0, sel} >= (SEL_W+1)'(N_IN));
    assign edge_det = sync2 & ~sync3;

`ifdef ROSEL_SATURATE_EN
    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
`else
    assign cnt_inc = cnt + 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel_q     <= '0;
            win_q     <= '0;
            timer     <= '0;
            cnt       <= '0;
            err_q     <= 1'b0;
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync3     <= 1'b0;
            done_r    <= 1'b0;
            sel_err_r <= 1'b0;
            count_r   <= '0;
        end else begin
            sync1     <= ro_sel;
            sync2     <= sync1;
            sync3     <= sync2;
            done_r    <= 1'b0;
            sel_err_r <= 1'b0;
            case (state)
                IDLE: begin
                    // The done cycle itself shows state IDLE; a start there is dropped
                    if (start && !done_r) begin
                        sel_q <= sel;
                        win_q <= window;
                        err_q <= sel_bad;
                        if (sel_bad) begin
                            state <= DONE;
                        end else begin
                            state <= SETTLE;
                            timer <= WIN_W'(2);
                        end
                    end
                end
                SETTLE: begin
                    cnt <= '0;
                    if (timer == '0) begin
                        if (win_q == '0) begin
                            state <= DONE;
                        end else begin
                            state <= COUNT;
                            timer <= win_q - 1'b1;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                COUNT: begin
                    if (edge_det) cnt <= cnt_inc;
                    if (timer == '0) state <= DONE;
                    else             timer <= timer - 1'b1;
                end
                DONE: begin
                    done_r    <= 1'b1;
                    sel_err_r <= err_q;
                    count_r   <= err_q ? '0 : cnt;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign done    = done_r;
    assign sel_err = sel_err_r;
    assign count   = count_r;

endmodule

// File: tb/tb_ro_puf_sel_counter.sv
// Directed bench for ro_puf_sel_counter: three instances (default, N_IN=12, CNT_W=4).
module tb_ro_puf_sel_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ro_in;
    logic [2:0]  start_v;
    logic [3:0]  sel;
    logic [15:0] window;

    logic        busy0, done0, err0;
    logic [15:0] count0;
    logic        busy1, done1, err1;
    logic [15:0] count1;
    logic        busy2, done2, err2;
    logic [3:0]  count2;

    int per [16];
    int cyc;
    int vectors;
    int miscompares;
    int ndone0;
    int lat, cv, ev;

    always #5 clk = ~clk;

    ro_puf_sel_counter #(.N_IN(16)) u_dut0 (
        .clk(clk), .rst(rst), .ro_in(ro_in), .start(start_v[0]), .sel(sel),
        .window(window), .busy(busy0), .done(done0), .count(count0), .sel_err(err0));

    ro_puf_sel_counter #(.N_IN(12)) u_dut1 (
        .clk(clk), .rst(rst), .ro_in(ro_in[11:0]), .start(start_v[1]), .sel(sel),
        .window(window), .busy(busy1), .done(done1), .count(count1), .sel_err(err1));

    ro_puf_sel_counter #(.N_IN(16), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst(rst), .ro_in(ro_in), .start(start_v[2]), .sel(sel),
        .window(window), .busy(busy2), .done(done2), .count(count2), .sel_err(err2));

    // Oscillator model: bit i rises when cyc % per[i] == 0; per 0 holds it low
    initial begin
        cyc   = 0;
        ro_in = '0;
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 16; i++)
                ro_in[i] = (per[i] != 0) && ((cyc % per[i]) < (per[i] / 2));
        end
    end

    initial begin
        ndone0 = 0;
        forever begin
            @(negedge clk);
            if (done0) ndone0++;
        end
    end

    task automatic check(input string tag, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic dn(input int d);
        case (d)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    task automatic set_per(input int sel_bit, input int sel_p, input int other_p);
        for (int i = 0; i < 16; i++) per[i] = other_p;
        per[sel_bit] = sel_p;
    endtask

    // lat = cycles after the start edge at which done is seen; poke > 0 pulses start (sel=7) then
    task automatic measure(input int d, input int s, input int w, input int poke,
                           output int l, output int c, output int e);
        @(negedge clk);
        sel        = 4'(s);
        window     = 16'(w);
        start_v[d] = 1'b1;
        @(negedge clk);
        start_v = '0;
        l = 0;
        while (!dn(d) && l < w + 50) begin
            @(negedge clk);
            l++;
            if (poke > 0 && l == poke) begin
                sel        = 4'd7;
                start_v[d] = 1'b1;
            end else begin
                start_v = '0;
            end
        end
        start_v = '0;
        case (d)
            0:       begin c = int'(count0); e = int'(err0); end
            1:       begin c = int'(count1); e = int'(err1); end
            default: begin c = int'(count2); e = int'(err2); end
        endcase
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        start_v     = '0;
        sel         = '0;
        window      = '0;
        set_per(0, 0, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy0), 0);
        check("rst_done", int'(done0), 0);
        check("rst_count", int'(count0), 0);
        check("rst_sel_err", int'(err0), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic count
        set_per(5, 10, 6);
        measure(0, 5, 100, 0, lat, cv, ev);
        check("basic_lat", lat, 104);
        check("basic_count", cv, 10);
        check("basic_sel_err", ev, 0);

        // Isolation
        set_per(3, 0, 4);
        measure(0, 3, 50, 0, lat, cv, ev);
        check("iso_lat", lat, 54);
        check("iso_count", cv, 0);

        // N_IN=12: valid channel, then out of range
        set_per(5, 10, 6);
        measure(1, 5, 100, 0, lat, cv, ev);
        check("n12_count", cv, 10);
        measure(1, 13, 100, 0, lat, cv, ev);
        check("badsel_lat", lat, 1);
        check("badsel_err", ev, 1);
        check("badsel_count", cv, 0);

        // Zero window
        measure(0, 0, 0, 0, lat, cv, ev);
        check("win0_lat", lat, 4);
        check("win0_count", cv, 0);

        // Busy guard: channel 7 would give 20
        set_per(5, 10, 6);
        per[7] = 5;
        repeat (5) @(negedge clk);
        ndone0 = 0;
        measure(0, 5, 100, 50, lat, cv, ev);
        repeat (10) @(negedge clk);
        check("guard_lat", lat, 104);
        check("guard_count", cv, 10);
        check("guard_ndone", ndone0, 1);

        // Overflow on CNT_W=4: 20 edges
        set_per(2, 4, 6);
        measure(2, 2, 80, 0, lat, cv, ev);
        check("ovf_lat", lat, 84);
`ifdef ROSEL_SATURATE_EN
        check("ovf_count", cv, 15);
`else
        check("ovf_count", cv, 4);
`endif

        // Reset mid-run
        set_per(5, 10, 6);
        @(negedge clk);
        sel        = 4'd5;
        window     = 16'd100;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v = '0;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_busy", int'(busy0), 0);
        check("midrst_done", int'(done0), 0);
        check("midrst_count", int'(count0), 0);
        check("midrst_sel_err", int'(err0), 0);
        rst    = 1'b0;
        ndone0 = 0;
        repeat (130) @(negedge clk);
        check("stale_done", ndone0, 0);
        measure(0, 5, 100, 0, lat, cv, ev);
        check("restart_lat", lat, 104);
        check("restart_count", cv, 10);

        // Maximum window, 65535/5 edges
        set_per(7, 5, 6);
        measure(0, 7, 65535, 0, lat, cv, ev);
        check("maxwin_lat", lat, 65539);
        check("maxwin_count", cv, 13107);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
